ldst_sequencer: RTL and testbench

- Parametrised control-step generator for fetch plus the memory-class instructions ld, ldi and st.
- Produces the per-step datapath strobes that drive CPUDesignProject today: PCout, MARin, IncPC, Z/MDR/IR enables, Gra/Grb, BAout, Cout, Rin/Rout, Read, ramWE.
- Generalises the fixed T0–T7 ld sequence with selectable opcode, configurable memory wait states, a completion handshake and illegal-opcode detection.
- Sits between the instruction register and the datapath, in place of hand-driven control.

---
 rtl/ldst_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ldst_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ldst_sequencer.sv
// ldst_sequencer
// Control-step generator for instruction fetch plus the memory-class
// instructions ld, ldi and st. It replaces hand-driven control between the
// instruction register and the datapath.
//
// Optional feature macro: SINGLE_STEP_EN
//   When defined, the input step_req is added. A state transition or
//   wait-counter decrement happens only on edges where step_req = 1;
//   otherwise the machine holds and its outputs stay asserted.
//
// Ports:
//   clk      system clock, rising edge
//   clr      asynchronous active-high reset (forces IDLE, all outputs 0)
//   run      start request, sampled in IDLE and DONE
//   opcode   IR opcode field, latched into op_q when T3 is left
//   step_req single-step qualifier (SINGLE_STEP_EN only)
//   busy     high in every state except IDLE
//   done     one-cycle pulse in DONE
//   illegal  high with done when the latched opcode is not ld/ldi/st
//   step     IDLE=0, T0..T7=1..8, DONE=9 (wait cycles report their step)
//   PCout..ramWE  per-step datapath strobes, decoded from registered state
module ldst_sequencer #(
    parameter int                  OPCODE_W = 5,
    parameter logic [OPCODE_W-1:0] OP_LD    = OPCODE_W'(0),
    parameter logic [OPCODE_W-1:0] OP_LDI   = OPCODE_W'(1),
    parameter logic [OPCODE_W-1:0] OP_ST    = OPCODE_W'(2),
    parameter int                  MEM_WAIT = 0,
    parameter int                  WAIT_W   = 4
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
`ifdef SINGLE_STEP_EN
    input  logic                step_req,
`endif
    output logic                busy,
    output logic                done,
    output logic                illegal,
    output logic [3:0]          step,
    output logic                PCout,
    output logic                MARin,
    output logic                IncPC,
    output logic                ZLowIn,
    output logic                ZHighIn,
    output logic                ZLowout,
    output logic                PCin,
    output logic                Read,
    output logic                MDRin,
    output logic                MDRout,
    output logic                IRin,
    output logic                Grb,
    output logic                Gra,
    output logic                BAout,
    output logic                Yin,
    output logic                Cout,
    output logic                Rin,
    output logic                Rout,
    output logic                ramWE
);

    // State codes double as the reported step number.
    typedef enum logic [3:0] {
        S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
        S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_DONE = 4'd9
    } state_t;

    localparam logic [WAIT_W-1:0] MEM_WAIT_C = WAIT_W'(MEM_WAIT);

    state_t              state_q, state_d, nxt;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic                adv, is_ld, is_ldi, is_st, hold;

    function automatic logic legal_op(input logic [OPCODE_W-1:0] op);
        return (op == OP_LD) || (op == OP_LDI) || (op == OP_ST);
    endfunction

    // Steps whose duration is stretched by MEM_WAIT: the fetch read, the ld
    // operand read and the st memory write.
    function automatic logic wait_step(input state_t s, input logic ld, input logic st);
        return (s == S_T1) || (s == S_T6 && ld) || (s == S_T7 && st);
    endfunction

`ifdef SINGLE_STEP_EN
    assign adv = step_req;
`else
    assign adv = 1'b1;
`endif

    assign is_ld  = (op_q == OP_LD);
    assign is_ldi = (op_q == OP_LDI);
    assign is_st  = (op_q == OP_ST);
    assign hold   = wait_step(state_q, is_ld, is_st) && (wait_q != '0);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        nxt     = state_q;
        state_d = state_q;
        wait_d  = wait_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE: if (run) nxt = S_T0;
            S_T0:   nxt = S_T1;
            S_T1:   nxt = S_T2;
            S_T2:   nxt = S_T3;
            S_T3:   nxt = legal_op(opcode) ? S_T4 : S_DONE;
            S_T4:   nxt = S_T5;
            S_T5:   nxt = is_ldi ? S_DONE : S_T6;
            S_T6:   nxt = S_T7;
            S_T7:   nxt = S_DONE;
            S_DONE: nxt = run ? S_T0 : S_IDLE;
            default: nxt = S_IDLE;
        endcase
        if (adv) begin
            if (hold) begin
                wait_d = wait_q - 1'b1;
            end else begin
                state_d = nxt;
                // op_q is already valid for T6/T7 entry, since T3 precedes them.
                wait_d  = wait_step(nxt, is_ld, is_st) ? MEM_WAIT_C : '0;
                if (state_q == S_T3) op_d = opcode;
            end
        end
    end

    // Moore decode: state_q, wait_q and op_q only.
    always_comb begin
        {PCout, MARin, IncPC, ZLowIn, ZHighIn, ZLowout, PCin, Read, MDRin,
         MDRout, IRin, Grb, Gra, BAout, Yin, Cout, Rin, Rout, ramWE} = '0;
        done    = 1'b0;
        illegal = 1'b0;
        busy    = (state_q != S_IDLE);
        step    = state_q;
        case (state_q)
            S_T0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; ZLowIn = 1'b1; end
            S_T1: begin
                ZLowout = 1'b1;
                Read    = 1'b1;
                PCin    = (wait_q == MEM_WAIT_C); // first cycle of the step
                MDRin   = (wait_q == '0);         // last cycle of the step
            end
            S_T2: begin MDRout = 1'b1; IRin = 1'b1; end
            S_T3: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
            S_T4: begin Cout = 1'b1; ZHighIn = 1'b1; ZLowIn = 1'b1; end
            S_T5: begin
                ZLowout = 1'b1;
                if (is_ldi) begin Gra = 1'b1; Rin = 1'b1; end
                else        MARin = 1'b1;
            end
            S_T6: begin
                if (is_ld) begin
                    Read  = 1'b1;
                    MDRin = (wait_q == '0);
                end else if (is_st) begin
                    Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld)      begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                else if (is_st) ramWE = 1'b1;
            end
            S_DONE: begin
                done    = 1'b1;
                illegal = !legal_op(op_q);
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ldst_sequencer.sv
// Bench for ldst_sequencer: three instances with MEM_WAIT = 0, 2, 3 driven
// from a table of per-cycle vectors plus hand-written reset, abort and
// cycle-count sequences.
module tb_ldst_sequencer;

    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_LDI = 5'b00001;
    localparam logic [4:0] OP_ST  = 5'b00010;
    localparam logic [4:0] OP_BAD = 5'b00011;

    // Strobe bit positions in the packed strobe vector.
    localparam logic [18:0] PCOUT = 19'd1 << 18, MARIN = 19'd1 << 17, INCPC = 19'd1 << 16,
                            ZLOWIN = 19'd1 << 15, ZHIGHIN = 19'd1 << 14, ZLOWOUT = 19'd1 << 13,
                            PCIN = 19'd1 << 12, READ = 19'd1 << 11, MDRIN = 19'd1 << 10,
                            MDROUT = 19'd1 << 9, IRIN = 19'd1 << 8, GRB = 19'd1 << 7,
                            GRA = 19'd1 << 6, BAOUT = 19'd1 << 5, YIN = 19'd1 << 4,
                            COUT = 19'd1 << 3, RIN = 19'd1 << 2, ROUT = 19'd1 << 1,
                            RAMWE = 19'd1;
    localparam logic [18:0] X_T0 = PCOUT | MARIN | INCPC | ZLOWIN;
    localparam logic [18:0] X_T2 = MDROUT | IRIN;
    localparam logic [18:0] X_T3 = GRB | BAOUT | YIN;
    localparam logic [18:0] X_T4 = COUT | ZHIGHIN | ZLOWIN;

    logic             clk = 1'b0;
    logic [2:0]       clr_i = '1;
    logic [2:0]       run_i = '0;
    logic [2:0]       sreq = '1;
    logic [2:0][4:0]  opc = '0;
    logic [2:0]       busy, done, ill;
    logic [2:0][3:0]  stp;
    logic [2:0][18:0] strb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        ldst_sequencer #(.MEM_WAIT(gi == 0 ? 0 : gi + 1)) u_dut (
            .clk(clk), .clr(clr_i[gi]), .run(run_i[gi]), .opcode(opc[gi]),
`ifdef SINGLE_STEP_EN
            .step_req(sreq[gi]),
`endif
            .busy(busy[gi]), .done(done[gi]), .illegal(ill[gi]), .step(stp[gi]),
            .PCout(strb[gi][18]), .MARin(strb[gi][17]), .IncPC(strb[gi][16]),
            .ZLowIn(strb[gi][15]), .ZHighIn(strb[gi][14]), .ZLowout(strb[gi][13]),
            .PCin(strb[gi][12]), .Read(strb[gi][11]), .MDRin(strb[gi][10]),
            .MDRout(strb[gi][9]), .IRin(strb[gi][8]), .Grb(strb[gi][7]),
            .Gra(strb[gi][6]), .BAout(strb[gi][5]), .Yin(strb[gi][4]),
            .Cout(strb[gi][3]), .Rin(strb[gi][2]), .Rout(strb[gi][1]),
            .ramWE(strb[gi][0])
        );
    end

    typedef struct {
        int          idx;
        logic        run;
        logic [4:0]  opc;
        logic [3:0]  step;
        logic [18:0] strb;
        logic        done;
        logic        ill;
    } vec_t;

    vec_t vec[$];

    task automatic add(input int idx, input logic r, input logic [4:0] o, input logic [3:0] s,
                       input logic [18:0] sb, input logic d, input logic il);
        vec_t v;
        v.idx = idx; v.run = r; v.opc = o; v.step = s; v.strb = sb; v.done = d; v.ill = il;
        vec.push_back(v);
    endtask

    task automatic check_vec(input int n, input vec_t v);
        logic eb;
        eb = (v.step != 4'd0);
        checks++;
        if (stp[v.idx] !== v.step || strb[v.idx] !== v.strb || done[v.idx] !== v.done ||
            ill[v.idx] !== v.ill || busy[v.idx] !== eb) begin
            errors++;
            $display("FAIL vec%0d dut%0d: got step=%0d strb=%h done=%b ill=%b busy=%b, want step=%0d strb=%h done=%b ill=%b busy=%b",
                     n, v.idx, stp[v.idx], strb[v.idx], done[v.idx], ill[v.idx], busy[v.idx],
                     v.step, v.strb, v.done, v.ill, eb);
        end else begin
            $display("vec%0d dut%0d step=%0d strb=%h done=%b ill=%b ok", n, v.idx, v.step, v.strb, v.done, v.ill);
        end
        checks++;
        if ((strb[v.idx][11] && strb[v.idx][0]) || (strb[v.idx][2] && strb[v.idx][1])) begin
            errors++;
            $display("FAIL invariant vec%0d dut%0d: strb=%h has Read&ramWE or Rin&Rout", n, v.idx, strb[v.idx]);
        end
    endtask

    task automatic check_zero(input int idx, input string name);
        checks++;
        if (stp[idx] !== 4'd0 || strb[idx] !== '0 || done[idx] !== 1'b0 ||
            ill[idx] !== 1'b0 || busy[idx] !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d: got step=%0d strb=%h done=%b ill=%b busy=%b, want all zero",
                     name, idx, stp[idx], strb[idx], done[idx], ill[idx], busy[idx]);
        end else begin
            $display("%s dut%0d all outputs zero ok", name, idx);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end else begin
            $display("%s = %0d ok", name, got);
        end
    endtask

    // Starts an instruction and counts cycles (state after each edge) until done.
    task automatic run_to_done(input int idx, input logic [4:0] o, output int n,
                               output int we_seen, output logic ill_at_done);
        n = 0; we_seen = 0; ill_at_done = 1'b0;
        opc[idx] = o;
        run_i[idx] = 1'b1;
        while (n < 60) begin
            @(negedge clk);
            n++;
            run_i[idx] = 1'b0;
            if (strb[idx][0]) we_seen++;
            if (done[idx]) begin
                ill_at_done = ill[idx];
                break;
            end
        end
    endtask

    initial begin
        int n, we;
        logic il;

        // ld, MEM_WAIT=0; run dropped after the first step.
        add(0,1,OP_LD,1,X_T0,0,0);                add(0,0,OP_LD,2,ZLOWOUT|PCIN|READ|MDRIN,0,0);
        add(0,0,OP_LD,3,X_T2,0,0);                add(0,0,OP_LD,4,X_T3,0,0);
        add(0,0,OP_LD,5,X_T4,0,0);                add(0,0,OP_LD,6,ZLOWOUT|MARIN,0,0);
        add(0,0,OP_LD,7,READ|MDRIN,0,0);          add(0,0,OP_LD,8,MDROUT|GRA|RIN,0,0);
        add(0,0,OP_LD,9,'0,1,0);                  add(0,0,OP_LD,0,'0,0,0);
        // ldi, MEM_WAIT=0: DONE right after T5.
        add(0,1,OP_LDI,1,X_T0,0,0);               add(0,0,OP_LDI,2,ZLOWOUT|PCIN|READ|MDRIN,0,0);
        add(0,0,OP_LDI,3,X_T2,0,0);               add(0,0,OP_LDI,4,X_T3,0,0);
        add(0,0,OP_LDI,5,X_T4,0,0);               add(0,0,OP_LDI,6,ZLOWOUT|GRA|RIN,0,0);
        add(0,0,OP_LDI,9,'0,1,0);                 add(0,0,OP_LDI,0,'0,0,0);
        // illegal opcode: DONE after T3 with illegal.
        add(0,1,OP_BAD,1,X_T0,0,0);               add(0,0,OP_BAD,2,ZLOWOUT|PCIN|READ|MDRIN,0,0);
        add(0,0,OP_BAD,3,X_T2,0,0);               add(0,0,OP_BAD,4,X_T3,0,0);
        add(0,0,OP_BAD,9,'0,1,1);                 add(0,0,OP_BAD,0,'0,0,0);
        // Two ld back to back with run held: DONE goes straight to T0.
        add(0,1,OP_LD,1,X_T0,0,0);                add(0,1,OP_LD,2,ZLOWOUT|PCIN|READ|MDRIN,0,0);
        add(0,1,OP_LD,3,X_T2,0,0);                add(0,1,OP_LD,4,X_T3,0,0);
        add(0,1,OP_LD,5,X_T4,0,0);                add(0,1,OP_LD,6,ZLOWOUT|MARIN,0,0);
        add(0,1,OP_LD,7,READ|MDRIN,0,0);          add(0,1,OP_LD,8,MDROUT|GRA|RIN,0,0);
        add(0,1,OP_LD,9,'0,1,0);                  add(0,1,OP_LD,1,X_T0,0,0);
        add(0,0,OP_LD,2,ZLOWOUT|PCIN|READ|MDRIN,0,0); add(0,0,OP_LD,3,X_T2,0,0);
        add(0,0,OP_LD,4,X_T3,0,0);                add(0,0,OP_LD,5,X_T4,0,0);
        add(0,0,OP_LD,6,ZLOWOUT|MARIN,0,0);       add(0,0,OP_LD,7,READ|MDRIN,0,0);
        add(0,0,OP_LD,8,MDROUT|GRA|RIN,0,0);      add(0,0,OP_LD,9,'0,1,0);
        add(0,0,OP_LD,0,'0,0,0);
        // st, MEM_WAIT=2: T1 and T7 each last 3 cycles, done at cycle 13.
        add(1,1,OP_ST,1,X_T0,0,0);                add(1,0,OP_ST,2,ZLOWOUT|PCIN|READ,0,0);
        add(1,0,OP_ST,2,ZLOWOUT|READ,0,0);        add(1,0,OP_ST,2,ZLOWOUT|READ|MDRIN,0,0);
        add(1,0,OP_ST,3,X_T2,0,0);                add(1,0,OP_ST,4,X_T3,0,0);
        add(1,0,OP_ST,5,X_T4,0,0);                add(1,0,OP_ST,6,ZLOWOUT|MARIN,0,0);
        add(1,0,OP_ST,7,GRA|ROUT|MDRIN,0,0);      add(1,0,OP_ST,8,RAMWE,0,0);
        add(1,0,OP_ST,8,RAMWE,0,0);               add(1,0,OP_ST,8,RAMWE,0,0);
        add(1,0,OP_ST,9,'0,1,0);                  add(1,0,OP_ST,0,'0,0,0);

        // Reset state, with run asserted to show clr dominates.
        run_i = '1;
        #1;
        for (int i = 0; i < 3; i++) check_zero(i, "reset");
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 3; i++) check_zero(i, "reset_held");
        run_i = '0;
        clr_i = '0;
        @(negedge clk);

        foreach (vec[i]) begin
            run_i[vec[i].idx] = vec[i].run;
            opc[vec[i].idx]   = vec[i].opc;
            @(posedge clk);
            @(negedge clk);
            check_vec(i, vec[i]);
        end

        // Abort ld on MEM_WAIT=3 while in step 7 (T6 read).
        opc[2] = OP_LD;
        run_i[2] = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            run_i[2] = 1'b0;
            if (stp[2] == 4'd7) break;
        end
        check_int("cycles_to_step7", n, 10);
        check_int("step7_read", int'(strb[2][11]), 1);
        #2 clr_i[2] = 1'b1;
        #1 check_zero(2, "async_clr");
        @(negedge clk);
        check_zero(2, "clr_held");
        clr_i[2] = 1'b0;
        repeat (3) @(negedge clk);
        check_zero(2, "idle_after_clr");

        // Full cycle counts from run sample to done.
        run_to_done(2, OP_LD, n, we, il);
        check_int("ld_w3_cycles", n, 15);
        check_int("ld_w3_ramwe_cycles", we, 0);
        check_int("ld_w3_illegal", int'(il), 0);
        @(negedge clk);
        run_to_done(1, OP_LDI, n, we, il);
        check_int("ldi_w2_cycles", n, 9);
        @(negedge clk);
        run_to_done(1, OP_BAD, n, we, il);
        check_int("illegal_w2_cycles", n, 7);
        check_int("illegal_w2_flag", int'(il), 1);
        @(negedge clk);
        run_to_done(2, OP_ST, n, we, il);
        check_int("st_w3_cycles", n, 15);
        check_int("st_w3_ramwe_cycles", we, 4);
        @(negedge clk);

`ifdef SINGLE_STEP_EN
        // step_req on every third edge: each ld step lasts exactly 3 cycles.
        begin
            int cnt [10];
            int cyc;
            foreach (cnt[k]) cnt[k] = 0;
            opc[0] = OP_LD;
            run_i[0] = 1'b1;
            cyc = 0;
            for (int k = 0; k < 45; k++) begin
                sreq[0] = (cyc % 3 == 0);
                @(negedge clk);
                cyc++;
                if (stp[0] != 4'd0) run_i[0] = 1'b0;
                if (stp[0] <= 4'd9) cnt[stp[0]]++;
            end
            sreq[0] = 1'b1;
            for (int k = 1; k <= 9; k++) check_int($sformatf("single_step_len_step%0d", k), cnt[k], 3);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
